fpadd_acc_ctrl: RTL and testbench
=================================

# fpadd_acc_ctrl

Sequencing controller that accumulates a packet of 12-bit floating-point operands through the shared combinational FP adder in the scalar pipeline. The adder has a fixed contract: exponent(A) ≥ exponent(B), positive operands only, no zero encoding, and a silently wrapping exponent. This block enforces that contract:
- orders each operand pair by exponent;
- bypasses zeros;
- saturates on exponent overflow;
- frames results with valid/ready handshakes.

Word format: [11] sign (always 0 on output), [10:7] exponent e, [6:0] fraction f, value 1.f × 2^(e−7). Zero is [10:0] = 0.

## Interface
No parameters (width fixed at 12 by the adder format).

Clock and reset are fixed as one clock plus an asynchronous, active-high reset.
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand offered
- in_ready  out  1  controller accepts operand this cycle
- in_data  in  12  operand; bit 11 ignored (magnitude only)
- in_last  in  1  qualifies the final operand of a packet
- out_valid  out  1  packet sum available
- out_ready  in  1  consumer accepts sum
- out_data  out  12  packet sum, bit 11 = 0
- out_ovf  out  1  sticky: exponent overflow occurred in this packet
- out_count  out  8  operands accepted in packet (saturates at 255)
- add_a  out  12  adder operand with the larger-or-equal exponent
- add_b  out  12  adder operand with the smaller exponent
- add_z  in  12  adder result (combinational, same cycle)

## Operation
- State register: acc[11:0], acc_valid (accumulator holds a non-zero value), ovf, cnt[7:0], FSM state.
- FSM states:
  - IDLE: acc empty, in_ready = 1.
  - ACC: partial sum held, in_ready = 1.
  - HOLD: result presented, in_ready = 0, out_valid = 1.
- IDLE → ACC on accept without in_last.
- IDLE or ACC → HOLD on accept with in_last.
- HOLD → IDLE on out_valid && out_ready; acc, acc_valid, ovf and cnt clear in the same edge.
- Operand ordering is combinational every cycle. If acc[10:7] ≥ in_data[10:7], then add_a = acc, add_b = {0, in_data[10:0]}. Otherwise the two are swapped. Ties put acc on add_a.
- On accept, acc updates as follows:
  - Operand zero: acc unchanged.
  - acc_valid = 0: acc ← {0, in_data[10:0]}, acc_valid ← 1, adder result ignored.
  - Otherwise: acc ← add_z with bit 11 forced to 0.
- Overflow: add_a[10:7] = 15 and add_z[10:7] ≠ 15 (the exponent wrapped). Then acc ← 12'h7FF and ovf ← 1.
- Exponent difference ≥ 8 needs no special case: the adder returns add_a unchanged.
- cnt increments on every accept, zeros included, and saturates at 255.
- out_data = acc when acc_valid, else 12'h000. out_ovf = ovf. out_count = cnt.
- In HOLD, out_data, out_ovf and out_count are stable until the handshake.
- While out_valid = 1 and out_ready = 0, outputs hold indefinitely.
- add_a and add_b are driven every cycle, not only on accept. The adder is combinational, so unused results are ignored.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_ovf = 0, out_count = 0. The FSM enters IDLE, so in_ready = 1 on the first cycle after reset deasserts.
- add_a/add_b during reset: acc is 0, so add_a = 0 and add_b = {0, in_data[10:0]} if in_data[10:7] = 0. Otherwise they are swapped. Either way the adder result is ignored.
- Throughput: one operand per cycle, zero bubbles. Accept on the edge where in_valid && in_ready.
- Latency: out_valid rises in the cycle after the in_last accept.
- Back-to-back packets: in_ready returns to 1 in the cycle after the out handshake. There is no concurrent accept in HOLD, giving one dead cycle per packet.
- Reset mid-packet or during HOLD: state returns to IDLE immediately (asynchronous) and the partial sum is discarded.
- in_last on a zero operand still closes the packet. An all-zero packet gives out_data = 0 with the actual cnt.
- The critical path is acc → ordering mux → adder → saturation → acc. The design must close it in one cycle; no pipeline register inside the loop.

## Test plan
- Tie ordering: reset, then send 12'h3C0 (1.5) followed by 12'h380 (1.0) with last. Expect add_a = 12'h3C0 on the second accept, out_data = 12'h420 (2.5), out_count = 2, out_ovf = 0.
- Swap ordering: send 12'h380 followed by 12'h480 (4.0) with last. Expect add_a = 12'h480 and add_b = 12'h380 on the second accept, out_data = 12'h4A0 (5.0).
- Zero bypass: send 12'h000, then 12'h380, then 12'h000 with last. Expect out_data = 12'h380, out_count = 3. A single 12'h000 with last gives out_data = 0.
- Overflow: send 12'h7FF followed by 12'h7FF with last. Expect out_data = 12'h7FF, out_ovf = 1. The next packet (12'h380 with last) gives out_ovf = 0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid. Outputs must stay stable and in_ready must stay 0. Handshake, then in_ready = 1 on the next cycle.
- Reset mid-packet: accept 3 operands, assert rst asynchronously between edges. Expect out_valid = 0, out_count = 0 and in_ready = 1 after release. A new packet of 12'h380 with last gives 12'h380.

Source files
------------

// File: rtl/fpadd_acc_ctrl.sv
// fpadd_acc_ctrl: accumulates a packet of 12-bit FP operands through an external
// combinational adder. It orders each pair by exponent, bypasses zero operands,
// saturates on exponent wrap, and presents the packet sum with a valid/ready handshake.
module fpadd_acc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_data,
    output logic        out_ovf,
    output logic [7:0]  out_count,
    output logic [11:0] add_a,
    output logic [11:0] add_b,
    input  logic [11:0] add_z
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t      state;
    logic [11:0] acc;
    logic        acc_valid;
    logic        ovf;
    logic [7:0]  cnt;

    logic [11:0] opnd;      // operand magnitude, sign stripped
    logic [11:0] sum;       // adder result, sign stripped
    logic        in_zero;
    logic        swap;
    logic        accept;
    logic        ovf_now;
    logic [11:0] acc_nxt;
    logic        ovf_set;

    assign opnd    = in_data & 12'h7FF;
    assign sum     = add_z & 12'h7FF;
    assign in_zero = (opnd[10:0] == 11'd0);
    assign accept  = in_valid && in_ready;

    // Exponent ordering: acc stays on add_a unless the operand's exponent is strictly larger
    always_comb begin
        swap  = (opnd[10:7] > acc[10:7]);
        add_a = swap ? opnd : acc;
        add_b = swap ? acc  : opnd;
    end

    // An add that starts at exponent 15 and no longer ends there has wrapped
    assign ovf_now = (add_a[10:7] == 4'hF) && (sum[10:7] != 4'hF);

    // Next accumulator value for an accepted operand: zero bypass, first load, add, or saturate
    always_comb begin
        acc_nxt = acc;
        ovf_set = 1'b0;
        if (!in_zero) begin
            if (!acc_valid) begin
                acc_nxt = opnd;
            end else if (ovf_now) begin
                acc_nxt = 12'h7FF;
                ovf_set = 1'b1;
            end else begin
                acc_nxt = sum;
            end
        end
    end

    // Packet FSM with registered handshake outputs; accumulator state clears on the out handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= 12'h000;
            acc_valid <= 1'b0;
            ovf       <= 1'b0;
            cnt       <= 8'd0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        acc       <= acc_nxt;
                        acc_valid <= acc_valid | ~in_zero;
                        ovf       <= ovf | ovf_set;
                        if (cnt != 8'hFF)
                            cnt <= cnt + 8'd1;
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        acc       <= 12'h000;
                        acc_valid <= 1'b0;
                        ovf       <= 1'b0;
                        cnt       <= 8'd0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = acc_valid ? acc : 12'h000;
    assign out_ovf   = ovf;
    assign out_count = cnt;

endmodule

// File: tb/tb_fpadd_acc_ctrl.sv
// Directed bench for fpadd_acc_ctrl; includes a behavioural model of the shared adder.
module tb_fpadd_acc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_ovf;
    logic [7:0]  out_count;
    logic [11:0] add_a;
    logic [11:0] add_b;
    logic [11:0] add_z;

    int checks = 0;
    int errors = 0;
    logic [11:0] seen_a;
    logic [11:0] seen_b;

    fpadd_acc_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_count(out_count),
        .add_a(add_a), .add_b(add_b), .add_z(add_z)
    );

    always #5 clk = ~clk;

    // Adder model: exp(a) >= exp(b), truncating, exponent wraps silently
    function automatic logic [11:0] fadd(input logic [11:0] a, input logic [11:0] b);
        logic [3:0] ea, eb, d;
        logic [8:0] ma, mb, s;
        ea = a[10:7];
        eb = b[10:7];
        d  = ea - eb;
        ma = {2'b01, a[6:0]};
        mb = {2'b01, b[6:0]};
        if (d >= 4'd8) mb = 9'd0;
        else           mb = mb >> d;
        s = ma + mb;
        if (s[8]) return {1'b0, ea + 4'd1, s[7:1]};
        else      return {1'b0, ea, s[6:0]};
    endfunction

    always_comb add_z = fadd(add_a, add_b);

    // Offer one operand; records the adder operands seen just before the accepting edge
    task automatic drive(input logic [11:0] d, input logic l);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        #1;
        seen_a = add_a; seen_b = add_b;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drive_ready got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_data = 12'h000;
    endtask

    // Complete the output handshake
    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 12'h000; in_last = 1'b0; out_ready = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 12'h000) begin errors++; $display("FAIL rst_data got %h want 000", out_data); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", out_ovf); end
        checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d want 0", out_count); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", in_ready); end
    endtask

    task automatic test_tie();
        drive(12'h3C0, 1'b0);
        drive(12'h380, 1'b1);
        checks++; if (seen_a !== 12'h3C0) begin errors++; $display("FAIL tie_add_a got %h want 3c0", seen_a); end
        checks++; if (seen_b !== 12'h380) begin errors++; $display("FAIL tie_add_b got %h want 380", seen_b); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tie_latency got %b want 1", out_valid); end
        checks++; if (out_data !== 12'h420) begin errors++; $display("FAIL tie_data got %h want 420", out_data); end
        checks++; if (out_count !== 8'd2) begin errors++; $display("FAIL tie_count got %0d want 2", out_count); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL tie_ovf got %b want 0", out_ovf); end
        take();
    endtask

    task automatic test_swap();
        drive(12'h380, 1'b0);
        drive(12'h480, 1'b1);
        checks++; if (seen_a !== 12'h480) begin errors++; $display("FAIL swap_add_a got %h want 480", seen_a); end
        checks++; if (seen_b !== 12'h380) begin errors++; $display("FAIL swap_add_b got %h want 380", seen_b); end
        checks++; if (out_data !== 12'h4A0) begin errors++; $display("FAIL swap_data got %h want 4a0", out_data); end
        take();
    endtask

    task automatic test_zero();
        drive(12'h000, 1'b0);
        drive(12'h380, 1'b0);
        drive(12'h000, 1'b1);
        checks++; if (out_data !== 12'h380) begin errors++; $display("FAIL zero_data got %h want 380", out_data); end
        checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL zero_count got %0d want 3", out_count); end
        take();
        drive(12'h800, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zonly_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 12'h000) begin errors++; $display("FAIL zonly_data got %h want 000", out_data); end
        checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL zonly_count got %0d want 1", out_count); end
        take();
    endtask

    task automatic test_overflow();
        drive(12'h7FF, 1'b0);
        drive(12'hFFF, 1'b1);
        checks++; if (out_data !== 12'h7FF) begin errors++; $display("FAIL ovf_data got %h want 7ff", out_data); end
        checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", out_ovf); end
        take();
        drive(12'h380, 1'b1);
        checks++; if (out_data !== 12'h380) begin errors++; $display("FAIL ovf_next_data got %h want 380", out_data); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_next_flag got %b want 0", out_ovf); end
        take();
    endtask

    task automatic test_backpressure();
        drive(12'h480, 1'b0);
        drive(12'h380, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 12'h4A0 || out_count !== 8'd2 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got v=%b d=%h c=%0d r=%b want v=1 d=4a0 c=2 r=0",
                         i, out_valid, out_data, out_count, in_ready);
            end
        end
        take();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid got %b want 0", out_valid); end
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 300; i++) drive(12'h000, 1'b0);
        drive(12'h000, 1'b1);
        checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d want 255", out_count); end
        checks++; if (out_data !== 12'h000) begin errors++; $display("FAIL sat_data got %h want 000", out_data); end
        take();
    endtask

    task automatic test_reset_mid();
        drive(12'h380, 1'b0);
        drive(12'h380, 1'b0);
        drive(12'h380, 1'b0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", out_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", in_ready); end
        drive(12'h380, 1'b1);
        checks++; if (out_data !== 12'h380) begin errors++; $display("FAIL rmid_data got %h want 380", out_data); end
        checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL rmid_pcount got %0d want 1", out_count); end
        take();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_swap();
        test_zero();
        test_overflow();
        test_backpressure();
        test_count_sat();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
